mf_cen_nco_bank: RTL
====================

Name: mf_cen_nco_bank

Overview:
Parametrised bank of fractional clock-enable generators (NCOs) running from one fast reference clock, e.g. the 107.386 MHz core clock. Each channel produces a one-cycle clock-enable pulse and a square-wave phase output at a runtime-programmable fractional rate and start phase. Unlike a fixed-frequency PLL, channels can be retuned and phase-realigned at run time through a valid/ready configuration port. A settle counter drives a `locked` indication after every reconfiguration.

Parameters:
NUM_CH, 6, number of channels (1..16)
ACC_W, 32, phase accumulator width in bits (8..48)
SETTLE_CYC, 16, refclk cycles `locked` stays low after reset or a commit (>=1)

Ports:
refclk  in  1  single clock; every register is clocked on its rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  configuration request
cfg_ready  out  1  block can accept a configuration
cfg_ch  in  4  target channel index
cfg_all  in  1  1 = apply this config to all channels simultaneously (ignores cfg_ch)
cfg_en  in  1  channel run enable
cfg_inc  in  ACC_W  phase increment per refclk cycle; f_cen = f_refclk*cfg_inc/2^ACC_W
cfg_phase  in  ACC_W  accumulator load value (start phase)
cen  out  NUM_CH  per-channel one-cycle clock-enable pulse
outclk  out  NUM_CH  per-channel square wave (accumulator MSB)
locked  out  1  configuration settled

Behaviour:
- Reset (async, rst=1): every acc, inc and en cleared; cen=0, outclk=0, locked=0, cfg_ready=0; state=SETTLE with cnt=SETTLE_CYC-1.
- Release from reset: SETTLE proceeds on the following edges.
- States:
  - LOCKED: cfg_ready=1, locked=1.
  - APPLY: cfg_ready=0, locked=0.
  - SETTLE: cfg_ready=0, locked=0.
- Transitions:
  - LOCKED -> APPLY on an edge with cfg_valid&cfg_ready. cfg_ch, cfg_all, cfg_en, cfg_inc and cfg_phase are captured into holding registers on that edge.
  - APPLY -> SETTLE on the next edge. On that same edge, each selected channel loads inc=held inc, acc=held phase, en=held en. Its cen is forced 0 for that edge.
  - SETTLE: cnt decrements each edge. On the edge where cnt==0, go to LOCKED. `locked` therefore rises SETTLE_CYC+1 edges after the commit edge.
- cfg_valid while cfg_ready=0 is ignored. Requesters hold cfg_valid until the handshake.
- Channel selection:
  - cfg_all=1: every channel is selected and all load on the same edge, giving a phase-aligned restart.
  - cfg_all=0 with cfg_ch>=NUM_CH: handshake still accepted, no channel changes, full SETTLE still performed.
- Channel datapath, every edge outside its load edge:
  - en=1: {carry,acc_next}=acc+inc (ACC_W+1 bits, wraps modulo 2^ACC_W); acc<=acc_next; cen<=carry.
  - en=0: acc holds; cen<=0.
  - outclk<=acc_next MSB while enabled; outclk<=0 while disabled.
- Channels keep running through APPLY and SETTLE. Unselected channels are never disturbed.
- Latency:
  - cen is registered: asserted on the edge where the accumulator wraps, held for exactly one cycle.
  - inc=0 with en=1: cen stays 0; outclk stays constant at the phase MSB.
  - Maximum inc (all ones): cen high on every edge except the first after load, and except each 2^ACC_W-th edge.
- Simultaneous events: async rst overrides everything, including mid-APPLY or mid-SETTLE; the pending config is discarded.
- No combinational path from any input to any output.

Test Plan:
1. Reset -> cen=0, outclk=0, cfg_ready=0, locked=0; after release, locked=1 and cfg_ready=1 exactly SETTLE_CYC edges later (16).
2. Commit ch0, en=1, inc=0x40000000, phase=0 -> locked low for 17 edges; cen[0] pulses every 4th edge, first pulse 4 edges after load; outclk[0] is 2 high / 2 low; other channels unchanged.
3. Commit ch1, inc=0x40000000, phase=0x80000000 -> first cen[1] 2 edges after load.
4. Commit ch2, inc=0x55555555 -> 3 cen pulses per 9 edges, long-term average exact to within one pulse over 3000 edges.
5. cfg_all=1, en=1, inc=0x20000000, phase=0 -> all six cen pulse on identical edges (every 8th).
6. Negative cases:
   - cfg_valid during SETTLE -> no handshake.
   - cfg_ch=7 -> accepted, no channel changes, locked drops for 17 edges.
   - rst asserted mid-SETTLE -> all outputs 0 immediately, before any refclk edge.

Source files
------------

// File: rtl/mf_cen_nco_bank.sv
// mf_cen_nco_bank
//   Bank of NUM_CH fractional clock-enable generators (NCOs) on one reference
//   clock. Each channel adds a programmable increment to a phase accumulator
//   every cycle. It emits a one-cycle cen pulse on accumulator wrap and a
//   square wave taken from the accumulator MSB.
//   Channels are retuned and re-phased through a valid/ready config port.
//   After every commit a settle counter holds `locked` low.
//
// Ports
//   refclk     reference clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   cfg_valid  configuration request (held until cfg_ready)
//   cfg_ready  configuration can be accepted (only while locked)
//   cfg_ch     target channel; values >= NUM_CH select nothing
//   cfg_all    1 = load every channel on the same edge (phase-aligned restart)
//   cfg_en     channel run enable
//   cfg_inc    phase increment; f_cen = f_refclk * inc / 2^ACC_W
//   cfg_phase  accumulator load value
//   cen        per-channel one-cycle enable pulse (registered carry)
//   outclk     per-channel square wave (registered accumulator MSB)
//   locked     configuration settled

// One NCO channel. The load has priority over normal stepping. On the load
// edge cen is forced low, so the first pulse always comes from the new
// settings.
module mf_cen_nco_lane #(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic             ld_en,
  input  logic [ACC_W-1:0] ld_inc,
  input  logic [ACC_W-1:0] ld_phase,
  output logic             cen,
  output logic             outclk
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic             en;
  logic [ACC_W:0]   sum;

  // The extra top bit is the wrap carry that becomes cen.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      inc    <= '0;
      en     <= 1'b0;
      cen    <= 1'b0;
      outclk <= 1'b0;
    end else if (load) begin
      acc    <= ld_phase;
      inc    <= ld_inc;
      en     <= ld_en;
      cen    <= 1'b0;
      // Show the start phase right away, so that with inc=0 the output
      // sits at the phase MSB from the load edge on.
      outclk <= ld_en & ld_phase[ACC_W-1];
    end else if (en) begin
      acc    <= sum[ACC_W-1:0];
      cen    <= sum[ACC_W];
      outclk <= sum[ACC_W-1];
    end else begin
      cen    <= 1'b0;
      outclk <= 1'b0;
    end
  end
endmodule

module mf_cen_nco_bank #(
  parameter int NUM_CH     = 6,
  parameter int ACC_W      = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic              cfg_all,
  input  logic              cfg_en,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] cen,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  localparam logic [1:0] ST_LOCKED = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  typedef struct packed {
    logic             all;
    logic [3:0]       ch;
    logic             en;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] phase;
  } cfg_t;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  cfg_t             held;
  logic [NUM_CH-1:0] load;

  // The status outputs are pure decodes of the state register. No input
  // reaches an output without passing through a flop.
  assign cfg_ready = (state == ST_LOCKED);
  assign locked    = (state == ST_LOCKED);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= ST_SETTLE;
      cnt   <= CNT_INIT;
      held  <= '0;
    end else begin
      case (state)
        ST_LOCKED: begin
          if (cfg_valid) begin
            held  <= '{all: cfg_all, ch: cfg_ch, en: cfg_en,
                       inc: cfg_inc, phase: cfg_phase};
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          // The channels load on this edge (see load[] below).
          state <= ST_SETTLE;
          cnt   <= CNT_INIT;
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_LOCKED;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= ST_SETTLE;
          cnt   <= CNT_INIT;
        end
      endcase
    end
  end

  // An out-of-range cfg_ch matches no index. That request is still
  // accepted and settled, but it touches no channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = (state == ST_APPLY) && (held.all || (held.ch == 4'(g)));

    mf_cen_nco_lane #(.ACC_W(ACC_W)) u_lane (
      .refclk   (refclk),
      .rst      (rst),
      .load     (load[g]),
      .ld_en    (held.en),
      .ld_inc   (held.inc),
      .ld_phase (held.phase),
      .cen      (cen[g]),
      .outclk   (outclk[g])
    );
  end
endmodule
